uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver that feeds the command decoder. It runs from the system clock and generates its own oversampling tick. Data width, parity mode and stop-bit count are configurable. It validates the start bit, checks parity and stop bits, and reports errors. A one-cycle valid strobe enables the decoder, and a byte-match LED output is kept.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line bit rate
OVERSAMPLE, 16, ticks per bit; must be even and ≥4
DATA_BITS, 8, data bits per frame, 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
MATCH_BYTE, 8'h32, value that lights led; compared against data[7:0], zero-extended if DATA_BITS < 8

Ports:
clk_50mhz  input  1  system clock
reset  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line; idles high
data  output  DATA_BITS  last correctly received word, LSB first on the line
valid  output  1  one-cycle strobe when a good frame completes (decoder enable)
parity_err  output  1  one-cycle strobe on parity mismatch
frame_err  output  1  one-cycle strobe when a stop bit is sampled low
busy  output  1  high from start-edge detection until return to IDLE
led  output  1  high while data == MATCH_BYTE

Behaviour:
- Reset: one clock; the reset polarity and synchronicity above are fixed. On reset: data = 0, valid = 0, parity_err = 0, frame_err = 0, busy = 0, state = IDLE, all counters = 0, synchroniser = 1. Reset mid-frame abandons the frame with no strobes.
- Synchroniser: rx passes through 2 flip-flops (rx_s). All logic uses rx_s.
- Tick: divider DIV = CLK_HZ/(BAUD*OVERSAMPLE), rounded down, minimum 1. It emits a 1-cycle tick and free-runs except in IDLE, where it is held at 0 and restarts on start-edge detection.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: when rx_s = 0 → START, busy = 1.
- START: after OVERSAMPLE/2 ticks, re-sample rx_s.
  - If rx_s = 1 → false start, go to IDLE, no strobes.
  - Otherwise clear the tick count and go to DATA.
- DATA: every OVERSAMPLE ticks (mid-bit), shift rx_s into bit index 0..DATA_BITS-1.
  - After the last bit → PARITY if PARITY ≠ 0, else STOP.
- PARITY: sample at mid-bit.
  - Expected bit = XOR of data bits for even; its inverse for odd.
  - Record the mismatch, then go to STOP.
- STOP: sample STOP_BITS bits at mid-bit. Any stop bit sampled low marks a framing error.
- Completion, in the cycle after the final stop sample:
  - Framing error → frame_err = 1 for 1 cycle, data unchanged, go to WAIT_IDLE.
  - Parity error only → parity_err = 1 for 1 cycle, data unchanged, go to IDLE.
  - No error → data ← shift register, valid = 1 for 1 cycle, go to IDLE.
  - If both errors occur, only frame_err is asserted.
- WAIT_IDLE (break / stuck-low line): stay until rx_s = 1, then go to IDLE. A held-low line yields exactly one frame_err, not repeated frames.
- busy = 0 in IDLE only. On a good frame, busy falls in the same cycle valid rises.
- Latency: valid rises 2 clocks after the mid-point sample of the last stop bit (1 clock of state update plus the registered strobe). The value shown on data is stable from that cycle until the next good frame.
- Back-to-back frames: a new start edge in the cycle after returning to IDLE is accepted. No idle gap is required beyond STOP_BITS.
- led: combinational compare of the registered data; it is 0 after reset unless MATCH_BYTE = 0.
- Strobes never overlap: at most one of valid, parity_err or frame_err is high in any cycle.

Test Plan:
1. Use CLK_HZ = 1843200, BAUD = 115200 (DIV = 1) with 8N1. Send 0x32 → valid pulses once for 1 cycle, data = 0x32, led = 1. Then send 0xA5 → data = 0xA5, led = 0.
2. Use PARITY = 1 (even). Send 0x07 with parity bit 1 → valid, data = 0x07. Send 0x07 with parity bit 0 → parity_err pulses once, valid stays 0, data holds 0x07.
3. Send 0x55 with the stop bit forced low, then hold rx low for 40 bit-times → exactly one frame_err pulse and busy stays high. Release rx high → IDLE, busy = 0. Then send 0x11 → valid, data = 0x11.
4. Drive a 3-tick low glitch on idle rx → false start, no strobes, busy returns to 0 within OVERSAMPLE/2 + 3 ticks.
5. Use DATA_BITS = 7, STOP_BITS = 2, PARITY = 2 (odd). Send 0x41 back-to-back three times with no idle gap → three valid pulses, data = 0x41 each time. Repeat with the second stop bit low → frame_err.
6. Assert reset for 1 cycle during bit 4 of a frame → all outputs 0 on the next cycle, no strobe for the aborted frame. The next full frame 0x32 is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// uart_rx_param
// Parametrised UART receiver with an internal oversampling tick generator.
// A frame is a start bit, DATA_BITS data bits (LSB first), an optional
// even/odd parity bit and STOP_BITS stop bits. Good frames update data and
// pulse valid for one cycle. Bad frames pulse parity_err or frame_err and
// leave data unchanged.
//
// Ports
//   clk_50mhz   system clock
//   reset       synchronous, active-high reset
//   rx          asynchronous serial input, idles high
//   data        last correctly received word
//   valid       one-cycle strobe on a good frame
//   parity_err  one-cycle strobe on a parity mismatch (no framing error)
//   frame_err   one-cycle strobe when any stop bit is sampled low
//   busy        low only while the receiver is idle
//   led         high while data matches MATCH_BYTE
module uart_rx_param #(
    parameter int         CLK_HZ     = 50000000,
    parameter int         BAUD       = 115200,
    parameter int         OVERSAMPLE = 16,
    parameter int         DATA_BITS  = 8,
    parameter int         PARITY     = 0,
    parameter int         STOP_BITS  = 1,
    parameter logic [7:0] MATCH_BYTE = 8'h32
) (
    input  logic                 clk_50mhz,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic                 led
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W   = $clog2(DATA_BITS);
    localparam int LOW_W   = (DATA_BITS < 8) ? DATA_BITS : 8;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                state, state_next;
    logic                  rx_p0, rx_s;
    logic [DIV_W-1:0]      div_cnt;
    logic [TICK_W-1:0]     tick_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  par_r;
    logic                  frm_r;
    logic                  done;
    logic                  tick;
    logic                  mid;
    logic [7:0]            data_low;

    // Parity bit the transmitter should have sent for this word.
    function automatic logic par_expected(input logic [DATA_BITS-1:0] d);
        par_expected = (PARITY == 2) ? ~(^d) : (^d);
    endfunction

    // ---- stage: input synchroniser ----
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_s  <= rx_p0;
        end
    end

    // ---- stage: oversampling tick ----
    // Held at zero while idle so the first tick after a start edge is a
    // full divider period later, keeping mid-bit sampling aligned.
    assign tick = (state != S_IDLE) && (div_cnt == DIV_LAST);
    assign mid  = tick && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk_50mhz) begin
        if (reset || state == S_IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ---- stage: frame FSM next state ----
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_next = S_START;
            end
            S_START: begin
                if (tick && tick_cnt == TICK_HALF)
                    state_next = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (mid && bit_cnt == DATA_LAST)
                    state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (mid) state_next = S_STOP;
            end
            S_STOP: begin
                // Completion runs the cycle after the final stop sample.
                if (done) state_next = frm_r ? S_WAIT_IDLE : S_IDLE;
            end
            S_WAIT_IDLE: begin
                if (rx_s) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---- stage: frame FSM state, counters and result registers ----
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_r      <= 1'b0;
            frm_r      <= 1'b0;
            done       <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    par_r    <= 1'b0;
                    frm_r    <= 1'b0;
                    done     <= 1'b0;
                end
                S_START: begin
                    if (tick)
                        tick_cnt <= (tick_cnt == TICK_HALF) ? '0 : tick_cnt + 1'b1;
                end
                S_DATA: begin
                    if (tick) tick_cnt <= mid ? '0 : tick_cnt + 1'b1;
                    if (mid) begin
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (tick) tick_cnt <= mid ? '0 : tick_cnt + 1'b1;
                    if (mid) par_r <= (rx_s != par_expected(shreg));
                end
                S_STOP: begin
                    if (done) begin
                        // Framing error takes priority over parity error.
                        if (frm_r) begin
                            frame_err <= 1'b1;
                        end else if (par_r) begin
                            parity_err <= 1'b1;
                        end else begin
                            valid <= 1'b1;
                            data  <= shreg;
                        end
                    end else begin
                        if (tick) tick_cnt <= mid ? '0 : tick_cnt + 1'b1;
                        if (mid) begin
                            if (!rx_s) frm_r <= 1'b1;
                            if (bit_cnt == STOP_LAST) done <= 1'b1;
                            else                      bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---- stage: status outputs ----
    assign busy     = (state != S_IDLE);
    assign data_low = 8'(data[LOW_W-1:0]);
    assign led      = (data_low == MATCH_BYTE);

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int BT = 16;  // clocks per bit with DIV = 1, OVERSAMPLE = 16

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       rx_a, rx_b, rx_c;
    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic       valid_a, parity_err_a, frame_err_a, busy_a, led_a;
    logic       valid_b, parity_err_b, frame_err_b, busy_b, led_b;
    logic       valid_c, parity_err_c, frame_err_c, busy_c, led_c;

    int checks   = 0;
    int failures = 0;

    // kind: 1 = valid, 2 = parity_err, 3 = frame_err, 9 = overlapping strobes
    typedef struct {
        int       dut;
        int       kind;
        logic [8:0] d;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    // 8N1
    uart_rx_param #(.CLK_HZ(1843200), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1), .MATCH_BYTE(8'h32)) dut_a (
        .clk_50mhz(clk), .reset(reset), .rx(rx_a), .data(data_a), .valid(valid_a),
        .parity_err(parity_err_a), .frame_err(frame_err_a), .busy(busy_a), .led(led_a));

    // 8E1
    uart_rx_param #(.CLK_HZ(1843200), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
                    .PARITY(1), .STOP_BITS(1), .MATCH_BYTE(8'h32)) dut_b (
        .clk_50mhz(clk), .reset(reset), .rx(rx_b), .data(data_b), .valid(valid_b),
        .parity_err(parity_err_b), .frame_err(frame_err_b), .busy(busy_b), .led(led_b));

    // 7O2
    uart_rx_param #(.CLK_HZ(1843200), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(7),
                    .PARITY(2), .STOP_BITS(2), .MATCH_BYTE(8'h32)) dut_c (
        .clk_50mhz(clk), .reset(reset), .rx(rx_c), .data(data_c), .valid(valid_c),
        .parity_err(parity_err_c), .frame_err(frame_err_c), .busy(busy_c), .led(led_c));

    function automatic ev_t mk_ev(input int dut, input int kind, input logic [8:0] d);
        ev_t e;
        e.dut  = dut;
        e.kind = kind;
        e.d    = d;
        return e;
    endfunction

    // Every high strobe cycle becomes one observed event.
    always @(negedge clk) begin
        if (valid_a === 1'b1)      obs_q.push_back(mk_ev(0, 1, {1'b0, data_a}));
        if (parity_err_a === 1'b1) obs_q.push_back(mk_ev(0, 2, {1'b0, data_a}));
        if (frame_err_a === 1'b1)  obs_q.push_back(mk_ev(0, 3, {1'b0, data_a}));
        if ($countones({valid_a, parity_err_a, frame_err_a}) > 1) obs_q.push_back(mk_ev(0, 9, 9'd0));
        if (valid_b === 1'b1)      obs_q.push_back(mk_ev(1, 1, {1'b0, data_b}));
        if (parity_err_b === 1'b1) obs_q.push_back(mk_ev(1, 2, {1'b0, data_b}));
        if (frame_err_b === 1'b1)  obs_q.push_back(mk_ev(1, 3, {1'b0, data_b}));
        if ($countones({valid_b, parity_err_b, frame_err_b}) > 1) obs_q.push_back(mk_ev(1, 9, 9'd0));
        if (valid_c === 1'b1)      obs_q.push_back(mk_ev(2, 1, {2'b0, data_c}));
        if (parity_err_c === 1'b1) obs_q.push_back(mk_ev(2, 2, {2'b0, data_c}));
        if (frame_err_c === 1'b1)  obs_q.push_back(mk_ev(2, 3, {2'b0, data_c}));
        if ($countones({valid_c, parity_err_c, frame_err_c}) > 1) obs_q.push_back(mk_ev(2, 9, 9'd0));
    end

    task automatic set_rx(input int dut, input logic v);
        case (dut)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic hold(input int dut, input logic v, input int n);
        set_rx(dut, v);
        repeat (n) @(negedge clk);
    endtask

    // par: 0 none, 1 even, 2 odd; flip inverts the parity bit sent;
    // low_stop[s] forces stop bit s low.
    task automatic send_frame(input int dut, input logic [8:0] d, input int nbits,
                              input int par, input bit flip, input int nstop,
                              input logic [1:0] low_stop);
        logic p;
        p = 1'b0;
        hold(dut, 1'b0, BT);
        for (int i = 0; i < nbits; i++) begin
            hold(dut, d[i], BT);
            p = p ^ d[i];
        end
        if (par != 0) begin
            if (par == 2) p = ~p;
            if (flip)     p = ~p;
            hold(dut, p, BT);
        end
        for (int s = 0; s < nstop; s++) hold(dut, ~low_stop[s], BT);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid_a, parity_err_a, frame_err_a, busy_a, led_a} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl_a: got %b, expected 00000", {valid_a, parity_err_a, frame_err_a, busy_a, led_a});
        end
        checks++;
        if (data_a !== 8'h00) begin
            failures++; $display("FAIL reset_data_a: got %h, expected 00", data_a);
        end
        checks++;
        if ({valid_b, parity_err_b, frame_err_b, busy_b, led_b} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl_b: got %b, expected 00000", {valid_b, parity_err_b, frame_err_b, busy_b, led_b});
        end
        checks++;
        if (data_b !== 8'h00) begin
            failures++; $display("FAIL reset_data_b: got %h, expected 00", data_b);
        end
        checks++;
        if ({valid_c, parity_err_c, frame_err_c, busy_c, led_c} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl_c: got %b, expected 00000", {valid_c, parity_err_c, frame_err_c, busy_c, led_c});
        end
        checks++;
        if (data_c !== 7'h00) begin
            failures++; $display("FAIL reset_data_c: got %h, expected 00", data_c);
        end
    endtask

    task automatic test_basic_8n1();
        ev_t e, o;
        logic [7:0] words [2];
        words[0] = 8'h32;
        words[1] = 8'hA5;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk_ev(0, 1, {1'b0, words[k]}));
            send_frame(0, {1'b0, words[k]}, 8, 0, 1'b0, 1, 2'b00);
            hold(0, 1'b1, 20);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (obs_q.size() == 0) begin
                    failures++;
                    $display("FAIL basic_event: got none, expected dut=%0d kind=%0d data=%h", e.dut, e.kind, e.d);
                end else begin
                    o = obs_q.pop_front();
                    if (o.dut !== e.dut || o.kind !== e.kind || o.d !== e.d) begin
                        failures++;
                        $display("FAIL basic_event: got dut=%0d kind=%0d data=%h, expected dut=%0d kind=%0d data=%h",
                                 o.dut, o.kind, o.d, e.dut, e.kind, e.d);
                    end
                end
            end
            checks++;
            if (obs_q.size() != 0) begin
                failures++; $display("FAIL basic_extra: got %0d extra events, expected 0", obs_q.size());
                obs_q.delete();
            end
            checks++;
            if (data_a !== words[k]) begin
                failures++; $display("FAIL basic_data: got %h, expected %h", data_a, words[k]);
            end
            checks++;
            if (led_a !== (words[k] == 8'h32)) begin
                failures++; $display("FAIL basic_led: got %b, expected %b", led_a, (words[k] == 8'h32));
            end
            checks++;
            if (busy_a !== 1'b0) begin
                failures++; $display("FAIL basic_busy: got %b, expected 0", busy_a);
            end
        end
    endtask

    task automatic test_parity();
        ev_t e, o;
        exp_q.push_back(mk_ev(1, 1, 9'h007));
        send_frame(1, 9'h007, 8, 1, 1'b0, 1, 2'b00);
        hold(1, 1'b1, 20);
        exp_q.push_back(mk_ev(1, 2, 9'h007));
        send_frame(1, 9'h007, 8, 1, 1'b1, 1, 2'b00);
        hold(1, 1'b1, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL parity_event: got none, expected dut=%0d kind=%0d data=%h", e.dut, e.kind, e.d);
            end else begin
                o = obs_q.pop_front();
                if (o.dut !== e.dut || o.kind !== e.kind || o.d !== e.d) begin
                    failures++;
                    $display("FAIL parity_event: got dut=%0d kind=%0d data=%h, expected dut=%0d kind=%0d data=%h",
                             o.dut, o.kind, o.d, e.dut, e.kind, e.d);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL parity_extra: got %0d extra events, expected 0", obs_q.size());
            obs_q.delete();
        end
        checks++;
        if (data_b !== 8'h07) begin
            failures++; $display("FAIL parity_data: got %h, expected 07", data_b);
        end
    endtask

    task automatic test_frame_break();
        ev_t e, o;
        exp_q.push_back(mk_ev(0, 3, 9'h0A5));
        send_frame(0, 9'h055, 8, 0, 1'b0, 1, 2'b01);
        hold(0, 1'b0, 40 * BT);
        checks++;
        if (busy_a !== 1'b1) begin
            failures++; $display("FAIL break_busy_high: got %b, expected 1", busy_a);
        end
        hold(0, 1'b1, 10);
        checks++;
        if (busy_a !== 1'b0) begin
            failures++; $display("FAIL break_busy_release: got %b, expected 0", busy_a);
        end
        exp_q.push_back(mk_ev(0, 1, 9'h011));
        send_frame(0, 9'h011, 8, 0, 1'b0, 1, 2'b00);
        hold(0, 1'b1, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL break_event: got none, expected dut=%0d kind=%0d data=%h", e.dut, e.kind, e.d);
            end else begin
                o = obs_q.pop_front();
                if (o.dut !== e.dut || o.kind !== e.kind || o.d !== e.d) begin
                    failures++;
                    $display("FAIL break_event: got dut=%0d kind=%0d data=%h, expected dut=%0d kind=%0d data=%h",
                             o.dut, o.kind, o.d, e.dut, e.kind, e.d);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL break_extra: got %0d extra events, expected 0", obs_q.size());
            obs_q.delete();
        end
        checks++;
        if (data_a !== 8'h11) begin
            failures++; $display("FAIL break_data: got %h, expected 11", data_a);
        end
    endtask

    task automatic test_false_start();
        bit seen_busy;
        int fall_at;
        seen_busy = 1'b0;
        fall_at   = -1;
        hold(0, 1'b0, 3);
        set_rx(0, 1'b1);
        // Bound: OVERSAMPLE/2 + 3 ticks plus synchroniser and detection latency.
        for (int c = 3; c < 30; c++) begin
            if (busy_a === 1'b1) seen_busy = 1'b1;
            if (seen_busy && busy_a === 1'b0 && fall_at < 0) fall_at = c;
            @(negedge clk);
        end
        checks++;
        if (seen_busy !== 1'b1) begin
            failures++; $display("FAIL glitch_busy_seen: got %b, expected 1", seen_busy);
        end
        checks++;
        if (fall_at < 0 || fall_at > 8 + 3 + 3) begin
            failures++; $display("FAIL glitch_busy_fall: got cycle %0d, expected 0..14", fall_at);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            failures++; $display("FAIL glitch_busy_end: got %b, expected 0", busy_a);
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL glitch_extra: got %0d events, expected 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk_ev(2, 1, 9'h041));
            send_frame(2, 9'h041, 7, 2, 1'b0, 2, 2'b00);
        end
        hold(2, 1'b1, 20);
        checks++;
        if (data_c !== 7'h41) begin
            failures++; $display("FAIL b2b_data: got %h, expected 41", data_c);
        end
        exp_q.push_back(mk_ev(2, 3, 9'h041));
        send_frame(2, 9'h041, 7, 2, 1'b0, 2, 2'b10);
        hold(2, 1'b1, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL b2b_event: got none, expected dut=%0d kind=%0d data=%h", e.dut, e.kind, e.d);
            end else begin
                o = obs_q.pop_front();
                if (o.dut !== e.dut || o.kind !== e.kind || o.d !== e.d) begin
                    failures++;
                    $display("FAIL b2b_event: got dut=%0d kind=%0d data=%h, expected dut=%0d kind=%0d data=%h",
                             o.dut, o.kind, o.d, e.dut, e.kind, e.d);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL b2b_extra: got %0d extra events, expected 0", obs_q.size());
            obs_q.delete();
        end
        checks++;
        if (busy_c !== 1'b0) begin
            failures++; $display("FAIL b2b_busy: got %b, expected 0", busy_c);
        end
    endtask

    task automatic test_reset_mid_frame();
        ev_t e, o;
        logic [7:0] w;
        w = 8'h32;
        hold(0, 1'b0, BT);
        for (int i = 0; i < 4; i++) hold(0, w[i], BT);
        hold(0, w[4], 8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({valid_a, parity_err_a, frame_err_a, busy_a, led_a} !== 5'b0) begin
            failures++;
            $display("FAIL midreset_ctrl: got %b, expected 00000", {valid_a, parity_err_a, frame_err_a, busy_a, led_a});
        end
        checks++;
        if (data_a !== 8'h00) begin
            failures++; $display("FAIL midreset_data: got %h, expected 00", data_a);
        end
        hold(0, 1'b1, 2 * BT);
        exp_q.push_back(mk_ev(0, 1, 9'h032));
        send_frame(0, 9'h032, 8, 0, 1'b0, 1, 2'b00);
        hold(0, 1'b1, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL midreset_event: got none, expected dut=%0d kind=%0d data=%h", e.dut, e.kind, e.d);
            end else begin
                o = obs_q.pop_front();
                if (o.dut !== e.dut || o.kind !== e.kind || o.d !== e.d) begin
                    failures++;
                    $display("FAIL midreset_event: got dut=%0d kind=%0d data=%h, expected dut=%0d kind=%0d data=%h",
                             o.dut, o.kind, o.d, e.dut, e.kind, e.d);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL midreset_extra: got %0d extra events, expected 0", obs_q.size());
            obs_q.delete();
        end
        checks++;
        if (data_a !== 8'h32 || led_a !== 1'b1) begin
            failures++; $display("FAIL midreset_result: got data=%h led=%b, expected data=32 led=1", data_a, led_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity();
        test_frame_break();
        test_false_start();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
